// File: rtl/ram_rr_arbiter_if.sv
// Bus bundle between the two requesters, the shared RAM and the round-robin arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus RAM).
interface ram_rr_arbiter_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_wdata;
  logic              rsp0_valid;
  logic [DWIDTH-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_wdata;
  logic              rsp1_valid;
  logic [DWIDTH-1:0] rsp1_rdata;

  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_dout,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_dout,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin sharing of one synchronous-read RAM between two requesters, with a
// per-owner burst limit and routing of each read result back to its issuer.
module ram_rr_arbiter #(
  parameter int AWIDTH    = 3,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clock,
  input logic              reset,
  ram_rr_arbiter_if.slave  bus
);
  localparam int            CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic [CW-1:0]     r_burst_cnt;
  logic [CW-1:0]     w_burst_nxt;
  logic              r_rsp_pend;
  logic              r_rsp_id;

  logic              w_gnt;
  logic              w_gnt_id;
  logic              w_gnt_ok;
  logic              w_same_owner;
  logic              w_sel_we;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_din;

  // Burst continuation first, then the requester that did not win last, then the last winner.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 1'b0;
    if (r_state == OWN0 && bus.req0_valid && r_burst_cnt < BURST_LIM) begin
      w_gnt    = 1'b1;
      w_gnt_id = 1'b0;
    end else if (r_state == OWN1 && bus.req1_valid && r_burst_cnt < BURST_LIM) begin
      w_gnt    = 1'b1;
      w_gnt_id = 1'b1;
    end else if (r_last_grant ? bus.req0_valid : bus.req1_valid) begin
      w_gnt    = 1'b1;
      w_gnt_id = ~r_last_grant;
    end else if (r_last_grant ? bus.req1_valid : bus.req0_valid) begin
      w_gnt    = 1'b1;
      w_gnt_id = r_last_grant;
    end else begin
      w_gnt    = 1'b0;
      w_gnt_id = 1'b0;
    end
  end

  // Reset forces every outward grant effect low, even while valids are held.
  assign w_gnt_ok = w_gnt & ~reset;

  // Next owner and burst count.
  always_comb begin
    w_state_nxt  = IDLE;
    w_burst_nxt  = '0;
    w_same_owner = 1'b0;
    if (w_gnt) begin
      w_state_nxt  = w_gnt_id ? OWN1 : OWN0;
      w_same_owner = (r_state == w_state_nxt);
      if (w_same_owner) begin
        w_burst_nxt = (r_burst_cnt == BURST_LIM) ? r_burst_cnt : r_burst_cnt + CW'(1);
      end else begin
        w_burst_nxt = '0;
      end
    end else begin
      w_state_nxt = IDLE;
      w_burst_nxt = '0;
    end
  end

  // RAM command mux from the granted requester.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    if (w_gnt_ok) begin
      if (w_gnt_id) begin
        w_sel_we   = bus.req1_we;
        w_sel_addr = bus.req1_addr;
        w_sel_din  = bus.req1_wdata;
      end else begin
        w_sel_we   = bus.req0_we;
        w_sel_addr = bus.req0_addr;
        w_sel_din  = bus.req0_wdata;
      end
    end else begin
      w_sel_we   = 1'b0;
      w_sel_addr = '0;
      w_sel_din  = '0;
    end
  end

  assign bus.req0_ready = w_gnt_ok & ~w_gnt_id;
  assign bus.req1_ready = w_gnt_ok &  w_gnt_id;
  assign bus.ram_we     = w_sel_we;
  assign bus.ram_addr   = w_sel_addr;
  assign bus.ram_din    = w_sel_din;

  // Read data is live on ram_dout exactly one cycle after the read accept.
  assign bus.rsp0_valid = r_rsp_pend & ~r_rsp_id;
  assign bus.rsp1_valid = r_rsp_pend &  r_rsp_id;
  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_dout : '0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_dout : '0;

  // Arbitration state and the one-deep pending-response tracker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
      r_rsp_pend   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rsp_pend  <= w_gnt & ~w_sel_we;
      if (w_gnt) begin
        r_last_grant <= w_gnt_id;
        r_rsp_id     <= w_gnt_id;
      end else begin
        r_last_grant <= r_last_grant;
        r_rsp_id     <= r_rsp_id;
      end
    end
  end

endmodule
